mole_round_ctrl: RTL and testbench
==================================

Name: mole_round_ctrl

Overview:
Parametrised next-generation whack-a-mole round controller. It owns the game timer, the per-round timer, lives, score and difficulty level, and drives an N-target arena. It pulls target patterns from a pattern generator over a valid/ready handshake and judges button input against the latched pattern. It sits between the pattern generator and the 7-seg/LED drivers, and adds start/restart, lives, tick-based timing and a saturating score.

Parameters:
N_TGT, 7, number of targets/buttons (2..16)
SCORE_W, 8, score width
TIMER_W, 16, game and round counter width
GAME_TICKS, 60000, game length in ticks
LIVES, 3, misses allowed before game over (1..7)
LVL_STEP, 5, hits per level increment
BASE_ROUND, 5000, round length at level 0, in ticks
ROUND_DEC, 1000, round-length reduction per level
MIN_ROUND, 2000, round-length floor
MAX_LIT, 4, cap on lit targets per pattern

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tick  in  1  timebase enable pulse; timers count only when high
start  in  1  start/restart request, level-sampled
btn  in  N_TGT  synchronised button levels
pat  in  N_TGT  candidate pattern from generator
pat_valid  in  1  pat is valid
pat_ready  out  1  controller accepts pat this cycle
num_lit  out  3  requested lit count for generator
target  out  N_TGT  latched active pattern, 0 when not in WAIT
lockout  out  N_TGT  buttons locked for this round
score  out  SCORE_W  hit count, saturating
lives  out  3  remaining lives
level  out  4  difficulty level
game_over  out  1  high in OVER
busy  out  1  high in REQ or WAIT
hit_pulse  out  1  one-cycle pulse on a hit
miss_pulse  out  1  one-cycle pulse on a round timeout

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-high on `rst`.
- Reset values:
  - state=IDLE
  - score=0, level=0, lives=LIVES
  - target=0, lockout=0
  - game counter=GAME_TICKS, round counter=0
  - all pulses 0, pat_ready=0, game_over=0
- States: IDLE, REQ, WAIT, OVER.
- IDLE: on start → REQ.
- REQ:
  - pat_ready=1.
  - pat_valid && pat!=0 → latch target=pat, lockout=0, round counter=round_len, → WAIT.
  - pat_valid with pat==0 is consumed and ignored; stay in REQ.
- WAIT: eff = btn & ~lockout. Priority, highest first:
  1. Game timer expiry.
  2. Hit: (eff & target)==target → score+1 (saturate at all-ones), hit_pulse, → REQ.
  3. Wrong press: lockout |= eff & ~target; stay in WAIT.
  4. Round expiry → miss_pulse, lives-1. If lives becomes 0 → OVER, else → REQ.
- Game timer:
  - Decrements on tick in REQ and WAIT.
  - Expires on tick with counter==1; → OVER.
  - A hit in the expiry cycle is not scored.
- Round timer:
  - Decrements on tick in WAIT only.
  - Expires on tick with counter==1, so a round lasts exactly round_len ticks.
- OVER:
  - game_over=1; score and level held; target=0.
  - On start: score=0, level=0, lives=LIVES, game counter=GAME_TICKS, → REQ (no pass through IDLE).
- Level:
  - A step counter (0..LVL_STEP-1) increments per hit and wraps; level+1 on wrap, saturating at 15.
  - No division.
- Derived values, combinational from level, width TIMER_W, clamped:
  - round_len = max(BASE_ROUND − level·ROUND_DEC, MIN_ROUND), computed without underflow.
  - num_lit = min(1+level, MAX_LIT, N_TGT).
- Score saturation: when saturated, hits still advance the round and still pulse hit_pulse.
- Reset mid-game returns to the reset values within one cycle; pulses are never emitted in the reset cycle.
- The pattern handshake occurs only in REQ; pat_ready is low in every other state.

Decomposition:
- Shared package mole_pkg holds:
  - the state enum (IDLE, REQ, WAIT, OVER)
  - the default timing constants
  - a function computing round_len/num_lit from level
- One natural sub-module: mole_tick_timer. It is a loadable down-counter with tick enable and an `expire` output; it is instantiated twice, for the game timer and the round timer.

Test Plan:
1. Reset then start, pat_valid=1 with pat=7'b0000100, then btn=7'b0000100 → target=0000100 one cycle after accept; hit_pulse once; score=1; back in REQ with pat_ready=1.
2. Wrong press: target=0000011, btn=0001000 → lockout=0001000. Then btn=0001011 → hit (locked bit ignored); score increments and lockout clears on the next accept.
3. Timeout: tick every cycle, BASE_ROUND=4, LIVES=2, no presses → miss_pulse after exactly 4 ticks in WAIT; lives=1. Second timeout → lives=0, game_over=1.
4. Difficulty: LVL_STEP=2 with 4 hits → level=2, round_len=3000, num_lit=3. At level≥3 → round_len=2000 (floor).
5. Game expiry: GAME_TICKS=10, hit asserted on the expiry cycle → OVER, score unchanged. Then start → score=0, lives=LIVES, state REQ.
6. Zero pattern and saturation: pat=0 with pat_valid → stays REQ. SCORE_W=2 with 5 hits → score=3 and hit_pulse on every hit. rst asserted in WAIT → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/mole_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mole_pkg
//  Description : Shared state encoding, default timing and level-derived values
//  Revision    : 1.0 - initial release
// ============================================================================
package mole_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam int c_n_tgt      = 7;
    localparam int c_score_w    = 8;
    localparam int c_timer_w    = 16;
    localparam int c_game_ticks = 60000;
    localparam int c_lives      = 3;
    localparam int c_lvl_step   = 5;
    localparam int c_base_round = 5000;
    localparam int c_round_dec  = 1000;
    localparam int c_min_round  = 2000;
    localparam int c_max_lit    = 4;

    // Compare before subtracting so the round length never wraps below zero.
    function automatic int calc_round_len(input int lvl, input int base,
                                          input int dec, input int min_len);
        if (lvl * dec + min_len < base)
            return base - lvl * dec;
        return min_len;
    endfunction

    function automatic int calc_num_lit(input int lvl, input int max_lit, input int n_tgt);
        int n;
        n = lvl + 1;
        if (n > max_lit) n = max_lit;
        if (n > n_tgt)   n = n_tgt;
        if (n > 7)       n = 7;
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mole_round_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mole_round_ctrl_if
//  Description : Pattern-generator handshake between generator and controller
//  Revision    : 1.0 - initial release
// ============================================================================
interface mole_round_ctrl_if #(
    parameter int N_TGT = 7
);
    logic [N_TGT-1:0] pat;
    logic             pat_valid;
    logic             pat_ready;
    logic [2:0]       num_lit;

    modport master (output pat, pat_valid, input pat_ready, num_lit);
    modport slave  (input pat, pat_valid, output pat_ready, num_lit);
endinterface
`default_nettype wire

// File: rtl/mole_tick_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mole_tick_timer
//  Description : Loadable tick-enabled down-counter flagging expiry at count 1
//  Revision    : 1.0 - initial release
// ============================================================================
module mole_tick_timer #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_val,
    input  wire logic             i_en,
    output logic                  o_expire
);
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (i_load)
            count_d = i_load_val;
        else if (i_en && count_q != '0)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= RST_VAL;
        else     count_q <= count_d;
    end

    assign o_expire = i_en && (count_q == WIDTH'(1));
endmodule
`default_nettype wire

// File: rtl/mole_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mole_round_ctrl
//  Description : Whack-a-mole round controller: timers, lives, score, level
//  Revision    : 1.0 - initial release
// ============================================================================
module mole_round_ctrl
    import mole_pkg::*;
#(
    parameter int N_TGT      = c_n_tgt,
    parameter int SCORE_W    = c_score_w,
    parameter int TIMER_W    = c_timer_w,
    parameter int GAME_TICKS = c_game_ticks,
    parameter int LIVES      = c_lives,
    parameter int LVL_STEP   = c_lvl_step,
    parameter int BASE_ROUND = c_base_round,
    parameter int ROUND_DEC  = c_round_dec,
    parameter int MIN_ROUND  = c_min_round,
    parameter int MAX_LIT    = c_max_lit
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         tick,
    input  wire logic         start,
    input  wire logic [N_TGT-1:0] btn,
    mole_round_ctrl_if.slave  pat_if,
    output logic [N_TGT-1:0]  target,
    output logic [N_TGT-1:0]  lockout,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]        lives,
    output logic [3:0]        level,
    output logic              game_over,
    output logic              busy,
    output logic              hit_pulse,
    output logic              miss_pulse
);
    localparam int c_step_w = (LVL_STEP > 1) ? $clog2(LVL_STEP) : 1;

    state_t               state_d, state_q;
    logic [N_TGT-1:0]     target_d, target_q;
    logic [N_TGT-1:0]     lockout_d, lockout_q;
    logic [SCORE_W-1:0]   score_d, score_q;
    logic [2:0]           lives_d, lives_q;
    logic [3:0]           level_d, level_q;
    logic [c_step_w-1:0]  step_d, step_q;
    logic                 hit_d, hit_q;
    logic                 miss_d, miss_q;

    logic                 game_load, round_load, game_exp, round_exp;
    logic [N_TGT-1:0]     eff, stray;
    logic [TIMER_W-1:0]   round_len;

    assign round_len = TIMER_W'(calc_round_len(int'(level_q), BASE_ROUND, ROUND_DEC, MIN_ROUND));
    assign eff       = btn & ~lockout_q;
    assign stray     = eff & ~target_q;

    mole_tick_timer #(.WIDTH(TIMER_W), .RST_VAL(TIMER_W'(GAME_TICKS))) u_game_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (game_load),
        .i_load_val (TIMER_W'(GAME_TICKS)),
        .i_en       (tick && (state_q == REQ || state_q == WAIT)),
        .o_expire   (game_exp)
    );

    mole_tick_timer #(.WIDTH(TIMER_W), .RST_VAL('0)) u_round_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (round_load),
        .i_load_val (round_len),
        .i_en       (tick && state_q == WAIT),
        .o_expire   (round_exp)
    );

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        lockout_d  = lockout_q;
        score_d    = score_q;
        lives_d    = lives_q;
        level_d    = level_q;
        step_d     = step_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        game_load  = 1'b0;
        round_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    game_load = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (game_exp) begin
                    state_d = OVER;
                end else if (pat_if.pat_valid && pat_if.pat != '0) begin
                    target_d   = pat_if.pat;
                    lockout_d  = '0;
                    round_load = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (game_exp) begin
                    state_d = OVER;
                end else if ((eff & target_q) == target_q) begin
                    hit_d   = 1'b1;
                    state_d = REQ;
                    if (score_q != '1) score_d = score_q + 1'b1;
                    if (step_q == c_step_w'(LVL_STEP - 1)) begin
                        step_d = '0;
                        if (level_q != 4'hF) level_d = level_q + 4'd1;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end else if (stray != '0) begin
                    lockout_d = lockout_q | stray;
                end else if (round_exp) begin
                    miss_d  = 1'b1;
                    lives_d = lives_q - 3'd1;
                    state_d = (lives_q == 3'd1) ? OVER : REQ;
                end
            end
            OVER: begin
                if (start) begin
                    score_d   = '0;
                    level_d   = '0;
                    step_d    = '0;
                    lives_d   = 3'(LIVES);
                    game_load = 1'b1;
                    state_d   = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            target_q  <= '0;
            lockout_q <= '0;
            score_q   <= '0;
            lives_q   <= 3'(LIVES);
            level_q   <= '0;
            step_q    <= '0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            lockout_q <= lockout_d;
            score_q   <= score_d;
            lives_q   <= lives_d;
            level_q   <= level_d;
            step_q    <= step_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
        end
    end

    assign pat_if.pat_ready = (state_q == REQ);
    assign pat_if.num_lit   = 3'(calc_num_lit(int'(level_q), MAX_LIT, N_TGT));
    assign target           = (state_q == WAIT) ? target_q : '0;
    assign lockout          = lockout_q;
    assign score            = score_q;
    assign lives            = lives_q;
    assign level            = level_q;
    assign game_over        = (state_q == OVER);
    assign busy             = (state_q == REQ) || (state_q == WAIT);
    assign hit_pulse        = hit_q;
    assign miss_pulse       = miss_q;
endmodule
`default_nettype wire

// File: tb/tb_mole_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mole_round_ctrl
//  Description : Directed + randomized bench for mole_round_ctrl with a game model
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mole_round_ctrl;
    localparam int P_N      = 7;
    localparam int P_SW     = 3;
    localparam int P_TW     = 16;
    localparam int P_GAME   = 300;
    localparam int P_LIVES  = 2;
    localparam int P_STEP   = 2;
    localparam int P_BASE   = 6;
    localparam int P_DEC    = 2;
    localparam int P_MIN    = 3;
    localparam int P_MAXLIT = 4;
    localparam int P_SMAX   = (1 << P_SW) - 1;

    logic             clk = 1'b0;
    logic             rst, tick, start;
    logic [P_N-1:0]   btn, target, lockout;
    logic [P_SW-1:0]  score;
    logic [2:0]       lives;
    logic [3:0]       level;
    logic             game_over, busy, hit_pulse, miss_pulse;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mole_round_ctrl_if #(.N_TGT(P_N)) u_if ();

    mole_round_ctrl #(
        .N_TGT(P_N), .SCORE_W(P_SW), .TIMER_W(P_TW), .GAME_TICKS(P_GAME),
        .LIVES(P_LIVES), .LVL_STEP(P_STEP), .BASE_ROUND(P_BASE),
        .ROUND_DEC(P_DEC), .MIN_ROUND(P_MIN), .MAX_LIT(P_MAXLIT)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .btn(btn),
        .pat_if(u_if), .target(target), .lockout(lockout), .score(score),
        .lives(lives), .level(level), .game_over(game_over), .busy(busy),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
    );

    // Game model: mode 0 idle, 1 requesting, 2 waiting for press, 3 game over.
    int             m_mode, m_game, m_round, m_lives, m_score, m_level, m_hits;
    logic [P_N-1:0] m_target, m_lock;
    bit             m_hit, m_miss, m_ok = 1'b0;

    function automatic int exp_round_len(input int lvl);
        int r;
        r = P_BASE - lvl * P_DEC;
        return (r < P_MIN) ? P_MIN : r;
    endfunction

    function automatic int exp_num_lit(input int lvl);
        int n;
        n = lvl + 1;
        n = (n < P_MAXLIT) ? n : P_MAXLIT;
        return (n < P_N) ? n : P_N;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit             g_exp, r_exp;
        logic [P_N-1:0] pressed;
        m_hit  = 1'b0;
        m_miss = 1'b0;
        if (rst) begin
            m_ok = 1'b1; m_mode = 0; m_game = P_GAME; m_round = 0; m_lives = P_LIVES;
            m_score = 0; m_level = 0; m_hits = 0; m_target = '0; m_lock = '0;
            return;
        end
        if (!m_ok) return;
        g_exp   = tick && (m_mode == 1 || m_mode == 2) && m_game == 1;
        r_exp   = tick && m_mode == 2 && m_round == 1;
        pressed = btn & ~m_lock;
        if (tick && (m_mode == 1 || m_mode == 2) && m_game > 0) m_game--;
        if (tick && m_mode == 2 && m_round > 0) m_round--;
        case (m_mode)
            0: if (start) begin m_mode = 1; m_game = P_GAME; end
            1: begin
                if (g_exp) m_mode = 3;
                else if (u_if.pat_valid && u_if.pat != '0) begin
                    m_target = u_if.pat; m_lock = '0;
                    m_round  = exp_round_len(m_level); m_mode = 2;
                end
            end
            2: begin
                if (g_exp) m_mode = 3;
                else if ((pressed & m_target) == m_target) begin
                    m_hit = 1'b1; m_mode = 1;
                    if (m_score < P_SMAX) m_score++;
                    m_hits++;
                    if (m_hits == P_STEP) begin
                        m_hits = 0;
                        if (m_level < 15) m_level++;
                    end
                end else if ((pressed & ~m_target) != '0) begin
                    m_lock = m_lock | (pressed & ~m_target);
                end else if (r_exp) begin
                    m_miss = 1'b1; m_lives--;
                    m_mode = (m_lives == 0) ? 3 : 1;
                end
            end
            default: if (start) begin
                m_score = 0; m_level = 0; m_hits = 0; m_lives = P_LIVES;
                m_game = P_GAME; m_mode = 1;
            end
        endcase
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        if (m_ok) begin
            chk("pat_ready",  u_if.pat_ready, m_mode == 1);
            chk("num_lit",    u_if.num_lit,   exp_num_lit(m_level));
            chk("target",     target,         (m_mode == 2) ? m_target : '0);
            chk("lockout",    lockout,        m_lock);
            chk("score",      score,          m_score);
            chk("lives",      lives,          m_lives);
            chk("level",      level,          m_level);
            chk("game_over",  game_over,      m_mode == 3);
            chk("busy",       busy,           m_mode == 1 || m_mode == 2);
            chk("hit_pulse",  hit_pulse,      m_hit);
            chk("miss_pulse", miss_pulse,     m_miss);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic accept(input logic [P_N-1:0] p);
        u_if.pat = p; u_if.pat_valid = 1'b1;
        cyc();
        u_if.pat_valid = 1'b0;
    endtask

    task automatic press(input logic [P_N-1:0] b);
        btn = b;
        cyc();
        btn = '0;
    endtask

    task automatic measure_timeout(input int exp_ticks, input string name);
        int n;
        bit got;
        n = 0; got = 1'b0; tick = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            cyc();
            n++;
            if (miss_pulse) got = 1'b1;
        end
        tick = 1'b0;
        chk({name, "_seen"}, got, 1);
        chk({name, "_ticks"}, n, exp_ticks);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; start = 1'b0; btn = '0;
        u_if.pat = '0; u_if.pat_valid = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_score", score, 0);
        chk("rst_lives", lives, P_LIVES);
        chk("rst_ready", u_if.pat_ready, 0);
        chk("rst_over",  game_over, 0);

        start = 1'b1; cyc(); start = 1'b0;
        accept(7'b0000100);
        chk("lit_target", target, 7'b0000100);
        press(7'b0000100);
        chk("lit_hit", hit_pulse, 1);
        chk("lit_score1", score, 1);
        chk("lit_ready", u_if.pat_ready, 1);

        accept(7'b0000011);
        press(7'b0001000);
        chk("lit_lockout", lockout, 7'b0001000);
        press(7'b0001011);
        chk("lit_score2", score, 2);
        chk("lit_level1", level, 1);
        chk("lit_numlit", u_if.num_lit, 2);

        accept(7'b0000001);
        measure_timeout(4, "lvl1_timeout");
        chk("lit_lives1", lives, 1);

        accept(7'b0000000);
        chk("zero_pat_ready", u_if.pat_ready, 1);
        chk("zero_pat_target", target, 0);

        accept(7'b0000001); press(7'b0000001);
        accept(7'b0000001); press(7'b0000001);
        chk("lit_level2", level, 2);
        accept(7'b0000010);
        measure_timeout(3, "floor_timeout");
        chk("lit_over", game_over, 1);
        chk("lit_lives0", lives, 0);
        chk("lit_score_held", score, 4);

        start = 1'b1; cyc(); start = 1'b0;
        chk("restart_score", score, 0);
        chk("restart_lives", lives, P_LIVES);
        chk("restart_busy", busy, 1);

        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 499) == 0);
            start      = ($urandom_range(0, 9) == 0);
            tick       = ($urandom_range(0, 1) == 1);
            u_if.pat_valid = ($urandom_range(0, 2) == 0);
            u_if.pat   = ($urandom_range(0, 5) == 0) ? '0 : P_N'($urandom);
            case ($urandom_range(0, 3))
                0:       btn = '0;
                1:       btn = P_N'($urandom);
                2:       btn = m_target;
                default: btn = m_target | P_N'(1 << $urandom_range(0, P_N - 1));
            endcase
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
